// File: rtl/blocpu_program_loader.sv
// rtl/blocpu_program_loader.sv - byte-command program loader and run control for the blocpu core
module blocpu_program_loader #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [11:0] instr_data,
  output logic [15:0] instr_addr,
  output logic        instr_write,
  output logic        core_reset,
  output logic        core_running,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, RST, RESP
  } state_t;

  state_t        state, state_n;
  logic [7:0]    resp_n;
  logic [15:0]   addr_q;     // next address to be written
  logic [8:0]    words_q;    // words still to load, 1..256
  logic [3:0]    hi_q;       // instr[11:8] from the DATA_HI byte
  logic [TW-1:0] idle_q;     // idle cycles since the last byte of a LOAD
  logic [7:0]    rst_q;      // cycles already spent in RST
  logic          load_state;
  logic          timeout;

  assign tx_valid = (state == RESP);
  assign busy     = (state != IDLE);

  // Next-state decode; a timeout overrides whatever the load state would do.
  always_comb begin
    state_n    = state;
    resp_n     = tx_data;
    load_state = (state == ADDR_HI) || (state == ADDR_LO) || (state == COUNT) ||
                 (state == DATA_HI) || (state == DATA_LO);
    timeout    = load_state && !rx_valid && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD:          state_n = ADDR_HI;
            CMD_RUN, CMD_HALT: begin state_n = RESP; resp_n = ACK; end
            CMD_RESET:         state_n = RST;
            default:           begin state_n = RESP; resp_n = NAK; end
          endcase
        end
      end
      ADDR_HI: if (rx_valid) state_n = ADDR_LO;
      ADDR_LO: if (rx_valid) state_n = COUNT;
      COUNT:   if (rx_valid) state_n = DATA_HI;
      DATA_HI: if (rx_valid) state_n = DATA_LO;
      DATA_LO: begin
        if (rx_valid) begin
          if (words_q == 9'd1) begin
            state_n = RESP;
            resp_n  = ACK;
          end else begin
            state_n = DATA_HI;
          end
        end
      end
      RST: begin
        if (rst_q == 8'(RESET_CYCLES - 1)) begin
          state_n = RESP;
          resp_n  = ACK;
        end
      end
      RESP:    if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = RESP;
      resp_n  = NAK;
    end
  end

  // State and response byte registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_data <= 8'h00;
    end else begin
      state   <= state_n;
      tx_data <= resp_n;
    end
  end

  // Datapath: address/count capture, write strobe, core control and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= 16'h0000;
      words_q      <= 9'd0;
      hi_q         <= 4'h0;
      idle_q       <= '0;
      rst_q        <= 8'd0;
      instr_data   <= 12'h000;
      instr_addr   <= 16'h0000;
      instr_write  <= 1'b0;
      core_reset   <= 1'b1;
      core_running <= 1'b0;
    end else begin
      instr_write <= 1'b0;
      // core_reset is high exactly while the FSM sits in RST
      core_reset  <= (state_n == RST);
      idle_q      <= (load_state && !rx_valid && !timeout) ? idle_q + TW'(1) : '0;
      rst_q       <= (state == RST) ? rst_q + 8'd1 : 8'd0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == CMD_RUN) core_running <= 1'b1;
            else if (rx_data == CMD_LOAD || rx_data == CMD_HALT || rx_data == CMD_RESET)
              core_running <= 1'b0;
          end
          ADDR_HI: addr_q[15:8] <= rx_data;
          ADDR_LO: addr_q[7:0]  <= rx_data;
          COUNT:   words_q      <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          DATA_HI: hi_q         <= rx_data[3:0];
          DATA_LO: begin
            instr_data  <= {hi_q, rx_data};
            instr_addr  <= addr_q;
            instr_write <= 1'b1;
            addr_q      <= addr_q + 16'd1;
            words_q     <= words_q - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blocpu_program_loader.sv
// tb/tb_blocpu_program_loader.sv - directed self-checking bench for blocpu_program_loader
module tb_blocpu_program_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] instr_data;
  logic [15:0] instr_addr;
  logic        instr_write;
  logic        core_reset;
  logic        core_running;
  logic        busy;

  int vectors;
  int miscompares;
  int writes_seen;

  blocpu_program_loader #(
    .RESET_CYCLES   (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .instr_data   (instr_data),
    .instr_addr   (instr_addr),
    .instr_write  (instr_write),
    .core_reset   (core_reset),
    .core_running (core_running),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic handshake();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    writes_seen = 0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
    reset       = 1'b1;
    #2;
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_running", core_running, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_instr_write", instr_write, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("core_reset_release", core_reset, 1'b0);

    send_byte(8'h01);
    chk("load_busy", busy, 1'b1);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h2A);
    chk("w0_write", instr_write, 1'b1);
    chk("w0_addr", instr_addr, 16'h0010);
    chk("w0_data", instr_data, 12'h12A);
    chk("w0_no_tx", tx_valid, 1'b0);
    tick();
    chk("w0_one_cycle", instr_write, 1'b0);
    chk("w0_addr_hold", instr_addr, 16'h0010);
    send_byte(8'h02);
    send_byte(8'h01);
    chk("w1_write", instr_write, 1'b1);
    chk("w1_addr", instr_addr, 16'h0011);
    chk("w1_data", instr_data, 12'h201);
    chk("load_tx_valid", tx_valid, 1'b1);
    chk("load_tx_ack", tx_data, 8'h06);
    tick();
    chk("w1_one_cycle", instr_write, 1'b0);
    handshake();
    chk("load_idle", busy, 1'b0);
    chk("load_tx_drop", tx_valid, 1'b0);

    send_byte(8'h02);
    chk("run_running", core_running, 1'b1);
    chk("run_core_reset", core_reset, 1'b0);
    chk("run_ack", tx_data, 8'h06);
    handshake();
    send_byte(8'h02);
    chk("run2_running", core_running, 1'b1);
    chk("run2_ack", tx_data, 8'h06);
    chk("run2_valid", tx_valid, 1'b1);
    handshake();

    send_byte(8'h04);
    chk("rstcmd_running", core_running, 1'b0);
    chk("rstcmd_core_reset_c1", core_reset, 1'b1);
    send_byte(8'h01);
    chk("rstcmd_core_reset_c2", core_reset, 1'b1);
    tick();
    chk("rstcmd_core_reset_c3", core_reset, 1'b1);
    tick();
    chk("rstcmd_core_reset_c4", core_reset, 1'b1);
    chk("rstcmd_no_tx_yet", tx_valid, 1'b0);
    tick();
    chk("rstcmd_core_reset_end", core_reset, 1'b0);
    chk("rstcmd_tx_valid", tx_valid, 1'b1);
    chk("rstcmd_ack", tx_data, 8'h06);
    send_byte(8'h02);
    chk("resp_drop_rx_data", tx_data, 8'h06);
    chk("resp_drop_rx_valid", tx_valid, 1'b1);
    chk("resp_drop_running", core_running, 1'b0);
    handshake();
    chk("rstcmd_idle", busy, 1'b0);

    send_byte(8'h02);
    handshake();
    send_byte(8'h03);
    chk("halt_running", core_running, 1'b0);
    chk("halt_ack", tx_data, 8'h06);
    handshake();

    send_byte(8'h02);
    handshake();
    send_byte(8'h01);
    chk("load_clears_running", core_running, 1'b0);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'hFA);
    send_byte(8'hBC);
    chk("wrap_w0_addr", instr_addr, 16'hFFFF);
    chk("wrap_w0_data", instr_data, 12'hABC);
    send_byte(8'h03);
    send_byte(8'h45);
    chk("wrap_w1_write", instr_write, 1'b1);
    chk("wrap_w1_addr", instr_addr, 16'h0000);
    chk("wrap_w1_data", instr_data, 12'h345);
    chk("wrap_ack", tx_data, 8'h06);
    handshake();

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h20);
    for (int i = 0; i < 15; i++) tick();
    send_byte(8'h03);
    for (int i = 0; i < 19; i++) begin
      tick();
      if (instr_write) writes_seen++;
    end
    chk("to_gap_cleared_busy", busy, 1'b1);
    chk("to_not_yet", tx_valid, 1'b0);
    tick();
    chk("to_tx_valid", tx_valid, 1'b1);
    chk("to_nak", tx_data, 8'h15);
    chk("to_no_writes", writes_seen, 0);
    handshake();
    chk("to_idle", busy, 1'b0);

    send_byte(8'h7F);
    for (int i = 0; i < 5; i++) begin
      chk("nak_held_valid", tx_valid, 1'b1);
      chk("nak_held_data", tx_data, 8'h15);
      tick();
    end
    handshake();
    chk("nak_idle", busy, 1'b0);
    chk("nak_valid_drop", tx_valid, 1'b0);

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h05);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_core_reset", core_reset, 1'b1);
    chk("abort_instr_data", instr_data, 12'h000);
    chk("abort_instr_addr", instr_addr, 16'h0000);
    chk("abort_tx_valid", tx_valid, 1'b0);
    writes_seen = 0;
    rx_data     = 8'h77;
    rx_valid    = 1'b1;
    tick();
    rx_valid = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr_write || tx_valid) writes_seen++;
    end
    chk("abort_no_write_no_tx", writes_seen, 0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_core_reset_release", core_reset, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blocpu_program_loader.md
BLOCPU_PROGRAM_LOADER -- requirements
Module: blocpu_program_loader

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4, number of cycles core_reset is held per RESET command (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle-cycle limit between bytes of one LOAD command.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset is asynchronous and active-high.
REQ-005 SHALL have port rx_data  in  8  received byte, valid when rx_valid=1.
REQ-006 SHALL have port rx_valid  in  1  one-cycle strobe per received byte.
REQ-007 SHALL have port tx_data  out  8  status byte to transmitter.
REQ-008 SHALL have port tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-009 SHALL have port tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready.
REQ-010 SHALL have port instr_data  out  12  instruction word to core memory.
REQ-011 SHALL have port instr_addr  out  16  instruction memory address.
REQ-012 SHALL have port instr_write  out  1  one-cycle write strobe.
REQ-013 SHALL have port core_reset  out  1  drives core in_reset.
REQ-014 SHALL have port core_running  out  1  drives core in_running.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, RST, RESP.
REQ-017 SHALL in IDLE decode rx byte: 0x01 LOAD->ADDR_HI; 0x02 RUN; 0x03 HALT; 0x04 RESET->RST; any other -> RESP with 0x15 (NAK).
REQ-018 SHALL on LOAD accept clear core_running in the same edge.
REQ-019 SHALL take ADDR_HI, ADDR_LO bytes as start address (big-endian), then COUNT byte as word count N, with 0 meaning 256.
REQ-020 SHALL per word take DATA_HI byte bits[3:0] as instr[11:8] (bits[7:4] ignored) and DATA_LO byte as instr[7:0].
REQ-021 SHALL assert instr_write for exactly one cycle, the cycle after DATA_LO accept, with instr_addr/instr_data stable that cycle.
REQ-022 SHALL increment address by 1 after each write, wrapping 0xFFFF->0x0000.
REQ-023 SHALL after the Nth write enter RESP with 0x06 (ACK); otherwise return to DATA_HI.
REQ-024 SHALL count idle cycles in ADDR_HI..DATA_LO; counter clears on each rx_valid; on reaching TIMEOUT_CYCLES go to RESP with 0x15, words already written remain written.
REQ-025 SHALL on RUN set core_running=1, core_reset=0, respond 0x06; RUN while running still responds 0x06.
REQ-026 SHALL on HALT clear core_running, respond 0x06.
REQ-027 SHALL on RESET clear core_running, hold core_reset=1 for exactly RESET_CYCLES cycles in RST, then RESP with 0x06.
REQ-028 SHALL in RESP hold tx_valid=1 and tx_data constant until tx_ready=1, then return to IDLE next cycle.
REQ-029 SHALL drop rx bytes arriving in RST or RESP without state change.
REQ-030 SHALL never assert instr_write outside LOAD sequence; instr_data/instr_addr hold last value otherwise.

Reset
REQ-031 SHALL on reset=1 immediately force state IDLE, core_running=0, core_reset=1, instr_write=0, tx_valid=0, tx_data=0, instr_data=0, instr_addr=0, counters 0, busy=0.
REQ-032 SHALL release core_reset to 0 on the first clk edge after reset deasserts.
REQ-033 SHALL abort any in-progress LOAD on reset with no further writes and no response byte.

Verification
REQ-034 SHALL pass: LOAD 01 00 10 02 | 01 2A | 02 01 -> writes 0x12A@0x0010, 0x201@0x0011, then tx 0x06.
REQ-035 SHALL pass: LOAD addr 0xFFFF count 2 -> writes at 0xFFFF then 0x0000, tx 0x06.
REQ-036 SHALL pass: RESET with RESET_CYCLES=4 while running -> core_running=0 same edge, core_reset high 4 cycles, tx 0x06.
REQ-037 SHALL pass: LOAD header then silence TIMEOUT_CYCLES (test value 20) -> no write, tx 0x15, IDLE.
REQ-038 SHALL pass: byte 0x7F in IDLE with tx_ready low 5 cycles -> tx_valid held, tx_data 0x15 stable, IDLE after handshake.
REQ-039 SHALL pass: reset asserted between DATA_HI and DATA_LO -> outputs per REQ-031 without clock edge, no write, no tx.
